// File: rtl/vga_timing_gen_pkg.sv
// Shared types and timing helpers for the VGA timing generator.
// Mode encodings, pipeline control bundle and window arithmetic.
package vga_timing_gen_pkg;

  typedef enum logic [1:0] {
    MODE_FB    = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  typedef struct packed {
    logic  hs;
    logic  vs;
    logic  act;
    logic  fs;
    mode_e mode;
  } ctl_t;

  function automatic int line_total(
    input int act, input int fp,
    input int pw, input int bp
  );
    return act + fp + pw + bp;
  endfunction

  function automatic int sync_on(
    input int act, input int fp
  );
    return act + fp;
  endfunction

  function automatic int sync_off(
    input int act, input int fp,
    input int pw
  );
    return act + fp + pw;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pattern.sv
// Built-in test patterns: colour bars, checkerboard, gradient.
// Pure combinational map from pixel coordinate and mode to RGB.
module vga_timing_gen_pattern
  import vga_timing_gen_pkg::*;
#(
  parameter int C_bits_x       = 11,
  parameter int C_bits_y       = 11,
  parameter int C_resolution_x = 1024,
  parameter int C_depth        = 2
) (
  input  logic [C_bits_x-1:0] x_i,
  input  logic [C_bits_y-1:0] y_i,
  input  mode_e               mode_i,
  output logic [C_depth-1:0]  red_o,
  output logic [C_depth-1:0]  green_o,
  output logic [C_depth-1:0]  blue_o
);

  localparam int BAR_W =
    (C_resolution_x / 8 > 0) ? C_resolution_x / 8 : 1;
  localparam logic [C_bits_x-1:0] BAR_WX = C_bits_x'(BAR_W);
  localparam logic [C_bits_x-1:0] XB3 = C_bits_x'(8);
  localparam logic [C_bits_y-1:0] YB3 = C_bits_y'(8);

  logic [2:0] k;
  logic       chk;

  // Select the pattern colour for the current pixel
  always_comb begin
    k       = 3'(x_i / BAR_WX);
    chk     = (|(x_i & XB3)) ^ (|(y_i & YB3));
    red_o   = '0;
    green_o = '0;
    blue_o  = '0;
    unique case (mode_i)
      MODE_BARS: begin
        red_o   = {C_depth{k[2]}};
        green_o = {C_depth{k[1]}};
        blue_o  = {C_depth{k[0]}};
      end
      MODE_CHECK: begin
        red_o   = {C_depth{chk}};
        green_o = {C_depth{chk}};
        blue_o  = {C_depth{chk}};
      end
      MODE_GRAD: begin
        red_o   = C_depth'(x_i >> 3);
        green_o = C_depth'(x_i >> 3);
        blue_o  = C_depth'(x_i >> 3);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator with framebuffer prefetch.
// Outputs trail the raster counters by C_prefetch+2 cycles.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int C_resolution_x      = 1024,
  parameter int C_hsync_front_porch = 16,
  parameter int C_hsync_pulse       = 96,
  parameter int C_hsync_back_porch  = 44,
  parameter int C_resolution_y      = 768,
  parameter int C_vsync_front_porch = 10,
  parameter int C_vsync_pulse       = 2,
  parameter int C_vsync_back_porch  = 31,
  parameter int C_bits_x            = 11,
  parameter int C_bits_y            = 11,
  parameter int C_hsync_polarity    = 1,
  parameter int C_vsync_polarity    = 1,
  parameter int C_depth             = 2,
  parameter int C_prefetch          = 2
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [C_depth-1:0]  in_red,
  input  logic [C_depth-1:0]  in_green,
  input  logic [C_depth-1:0]  in_blue,
  output logic [C_bits_x-1:0] fetch_x,
  output logic [C_bits_y-1:0] fetch_y,
  output logic                fetch_valid,
  output logic [C_depth-1:0]  vga_red,
  output logic [C_depth-1:0]  vga_green,
  output logic [C_depth-1:0]  vga_blue,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_blank,
  output logic                frame_start
);

  localparam int BX = C_bits_x;
  localparam int BY = C_bits_y;
  localparam int P  = C_prefetch;

  localparam int H_TOTAL = line_total(C_resolution_x,
    C_hsync_front_porch, C_hsync_pulse, C_hsync_back_porch);
  localparam int V_TOTAL = line_total(C_resolution_y,
    C_vsync_front_porch, C_vsync_pulse, C_vsync_back_porch);

  localparam logic [BX-1:0] H_LAST = BX'(H_TOTAL - 1);
  localparam logic [BX-1:0] X_ACT  = BX'(C_resolution_x);
  localparam logic [BX-1:0] HS_ON  = BX'(sync_on(
    C_resolution_x, C_hsync_front_porch));
  localparam logic [BX-1:0] HS_OFF = BX'(sync_off(
    C_resolution_x, C_hsync_front_porch, C_hsync_pulse));

  localparam logic [BY-1:0] V_LAST = BY'(V_TOTAL - 1);
  localparam logic [BY-1:0] Y_ACT  = BY'(C_resolution_y);
  localparam logic [BY-1:0] VS_ON  = BY'(sync_on(
    C_resolution_y, C_vsync_front_porch));
  localparam logic [BY-1:0] VS_OFF = BY'(sync_off(
    C_resolution_y, C_vsync_front_porch, C_vsync_pulse));

  localparam logic HPOL = (C_hsync_polarity != 0);
  localparam logic VPOL = (C_vsync_polarity != 0);

  logic [BX-1:0] cx_q, cx_d;
  logic [BY-1:0] cy_q, cy_d;
  mode_e         mode_q, mode_d;
  logic          origin;
  ctl_t          ctl_d;

  logic [BX-1:0] fx_q;
  logic [BY-1:0] fy_q;
  logic          fv_q;

  ctl_t          ctl_q [0:P];
  logic [BX-1:0] x_q   [0:P];
  logic [BY-1:0] y_q   [0:P];

  logic [C_depth-1:0] pat_r, pat_g, pat_b;
  logic [C_depth-1:0] red_d, green_d, blue_d;
  logic [C_depth-1:0] red_q, green_q, blue_q;
  logic               hs_q, vs_q, blank_q, fs_q;

  // Raster counters and per-frame mode selection
  always_comb begin
    cx_d = cx_q + 1'b1;
    cy_d = cy_q;
    if (cx_q == H_LAST) begin
      cx_d = '0;
      cy_d = (cy_q == V_LAST) ? '0 : cy_q + 1'b1;
    end
    origin = (cx_q == '0) && (cy_q == '0);
    mode_d = origin ? mode_e'(mode) : mode_q;
    ctl_d.hs   = (cx_q >= HS_ON) && (cx_q < HS_OFF);
    ctl_d.vs   = (cy_q >= VS_ON) && (cy_q < VS_OFF);
    ctl_d.act  = (cx_q < X_ACT) && (cy_q < Y_ACT);
    ctl_d.fs   = origin;
    ctl_d.mode = mode_d;
  end

  // Counter, mode latch and fetch address registers
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cx_q   <= '0;
      cy_q   <= '0;
      mode_q <= MODE_FB;
      fx_q   <= '0;
      fy_q   <= '0;
      fv_q   <= 1'b0;
    end else begin
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      mode_q <= mode_d;
      fx_q   <= cx_q;
      fy_q   <= cy_q;
      fv_q   <= ctl_d.act;
    end
  end

  // Delay line matching the framebuffer read latency
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= P; i++) begin
        ctl_q[i] <= '0;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
      end
    end else begin
      ctl_q[0] <= ctl_d;
      x_q[0]   <= cx_q;
      y_q[0]   <= cy_q;
      for (int i = 1; i <= P; i++) begin
        ctl_q[i] <= ctl_q[i-1];
        x_q[i]   <= x_q[i-1];
        y_q[i]   <= y_q[i-1];
      end
    end
  end

  vga_timing_gen_pattern #(
    .C_bits_x       (C_bits_x),
    .C_bits_y       (C_bits_y),
    .C_resolution_x (C_resolution_x),
    .C_depth        (C_depth)
  ) u_pattern (
    .x_i     (x_q[P]),
    .y_i     (y_q[P]),
    .mode_i  (ctl_q[P].mode),
    .red_o   (pat_r),
    .green_o (pat_g),
    .blue_o  (pat_b)
  );

  // Colour source select, forced black outside the active area
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (ctl_q[P].act) begin
      if (ctl_q[P].mode == MODE_FB) begin
        red_d   = in_red;
        green_d = in_green;
        blue_d  = in_blue;
      end else begin
        red_d   = pat_r;
        green_d = pat_g;
        blue_d  = pat_b;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hs_q    <= ~HPOL;
      vs_q    <= ~VPOL;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hs_q    <= ctl_q[P].hs ? HPOL : ~HPOL;
      vs_q    <= ctl_q[P].vs ? VPOL : ~VPOL;
      blank_q <= ~ctl_q[P].act;
      fs_q    <= ctl_q[P].fs;
    end
  end

  assign fetch_x     = fx_q;
  assign fetch_y     = fy_q;
  assign fetch_valid = fv_q;
  assign vga_red     = red_q;
  assign vga_green   = green_q;
  assign vga_blue    = blue_q;
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign vga_blank   = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on an 8x4 raster.
// Two instances: active-high and active-low sync polarity.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] fb1, fb2;

  logic [3:0] fx, fx_n;
  logic [2:0] fy, fy_n;
  logic       fv, fv_n;
  logic [1:0] r, g, b, r_n, g_n, b_n;
  logic       hs, vs, bl, fs;
  logic       hs_n, vs_n, bl_n, fs_n;

  int tests = 0;
  int fails = 0;
  int n;

  logic       hs_t  [0:199];
  logic       vs_t  [0:199];
  logic       hsn_t [0:199];
  logic       vsn_t [0:199];
  logic       bl_t  [0:199];
  logic       fs_t  [0:199];
  logic       fv_t  [0:199];
  logic [5:0] rgb_t [0:199];

  logic [5:0] bars_exp [0:7] = '{
    6'h00, 6'h03, 6'h0C, 6'h0F,
    6'h30, 6'h33, 6'h3C, 6'h3F
  };

  always #5 clk = ~clk;

  // Framebuffer stand-in: returns fetch_x[1:0] two clocks later
  always @(posedge clk) begin
    fb1 <= fx[1:0];
    fb2 <= fb1;
  end

  vga_timing_gen #(
    .C_resolution_x(8), .C_hsync_front_porch(1),
    .C_hsync_pulse(2), .C_hsync_back_porch(1),
    .C_resolution_y(4), .C_vsync_front_porch(1),
    .C_vsync_pulse(1), .C_vsync_back_porch(1),
    .C_bits_x(4), .C_bits_y(3),
    .C_hsync_polarity(1), .C_vsync_polarity(1),
    .C_depth(2), .C_prefetch(2)
  ) dut (
    .clk_pixel(clk), .reset(rst), .mode(mode),
    .in_red(fb2), .in_green(fb2), .in_blue(fb2),
    .fetch_x(fx), .fetch_y(fy), .fetch_valid(fv),
    .vga_red(r), .vga_green(g), .vga_blue(b),
    .vga_hsync(hs), .vga_vsync(vs),
    .vga_blank(bl), .frame_start(fs)
  );

  vga_timing_gen #(
    .C_resolution_x(8), .C_hsync_front_porch(1),
    .C_hsync_pulse(2), .C_hsync_back_porch(1),
    .C_resolution_y(4), .C_vsync_front_porch(1),
    .C_vsync_pulse(1), .C_vsync_back_porch(1),
    .C_bits_x(4), .C_bits_y(3),
    .C_hsync_polarity(0), .C_vsync_polarity(0),
    .C_depth(2), .C_prefetch(2)
  ) dut_n (
    .clk_pixel(clk), .reset(rst), .mode(mode),
    .in_red(fb2), .in_green(fb2), .in_blue(fb2),
    .fetch_x(fx_n), .fetch_y(fy_n), .fetch_valid(fv_n),
    .vga_red(r_n), .vga_green(g_n), .vga_blue(b_n),
    .vga_hsync(hs_n), .vga_vsync(vs_n),
    .vga_blank(bl_n), .frame_start(fs_n)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    if (n < 200) begin
      hs_t[n]  = hs;
      vs_t[n]  = vs;
      hsn_t[n] = hs_n;
      vsn_t[n] = vs_n;
      bl_t[n]  = bl;
      fs_t[n]  = fs;
      fv_t[n]  = fv;
      rgb_t[n] = {r, g, b};
    end
  endtask

  task automatic hold_reset(input logic [1:0] m);
    rst  = 1'b1;
    mode = m;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    n   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;

    // Reset values
    hold_reset(2'd0);
    check("rst_blank", bl, 1);
    check("rst_hsync", hs, 0);
    check("rst_vsync", vs, 0);
    check("rst_hsync_n", hs_n, 1);
    check("rst_vsync_n", vs_n, 1);
    check("rst_rgb", {r, g, b}, 0);
    check("rst_fetch_valid", fv, 0);
    check("rst_frame_start", fs, 0);

    // Two frames in framebuffer mode; switch to checker at cx=5,cy=2
    release_reset();
    while (n < 180) begin
      if (n == 29) mode = 2'd2;
      step();
    end

    check("fv_first", fv_t[1], 1);
    check("fv_last_act", fv_t[8], 1);
    check("fv_blank", fv_t[9], 0);

    check("fs_before", fs_t[3], 0);
    check("fs_first", fs_t[4], 1);
    check("fs_second", fs_t[88], 1);
    cnt = 0;
    for (int i = 5; i < 88; i++) cnt += int'(fs_t[i]);
    check("fs_gap", cnt, 0);

    check("hs_pre", hs_t[12], 0);
    check("hs_rise", hs_t[13], 1);
    check("hs_hold", hs_t[14], 1);
    check("hs_fall", hs_t[15], 0);
    check("hs_period", hs_t[25], 1);
    cnt = 0;
    for (int i = 4; i < 172; i++) cnt += int'(hs_t[i]);
    check("hs_count", cnt, 28);

    check("vs_pre", vs_t[63], 0);
    check("vs_rise", vs_t[64], 1);
    check("vs_hold", vs_t[75], 1);
    check("vs_fall", vs_t[76], 0);
    check("vs_period", vs_t[148], 1);
    cnt = 0;
    for (int i = 4; i < 172; i++) cnt += int'(vs_t[i]);
    check("vs_count", cnt, 24);

    cnt = 0;
    for (int i = 4; i < 172; i++)
      cnt += int'(hsn_t[i] == hs_t[i]) + int'(vsn_t[i] == vs_t[i]);
    check("pol_inverse", cnt, 0);
    check("vs_n_low", vsn_t[64], 0);
    check("hs_n_low", hsn_t[13], 0);

    for (int l = 0; l < 7; l++) begin
      cnt = 0;
      for (int i = 4 + 12 * l; i < 16 + 12 * l; i++)
        cnt += int'(!bl_t[i]);
      check($sformatf("blank_line%0d", l), cnt, (l < 4) ? 8 : 0);
    end

    for (int k = 0; k < 8; k++)
      check($sformatf("fb_red_x%0d", k),
            32'(rgb_t[4 + k][5:4]), k % 4);
    check("fb_blank_black", rgb_t[13], 0);

    check("switch_same_frame_a", 32'(rgb_t[34][5:4]), 2);
    check("switch_same_frame_b", 32'(rgb_t[35][5:4]), 3);
    check("switch_same_frame_c", 32'(rgb_t[41][5:4]), 1);
    check("checker_next_frame_a", rgb_t[89], 0);
    check("checker_next_frame_b", rgb_t[90], 0);
    check("checker_next_frame_c", rgb_t[91], 0);

    // Colour bars on line 0
    hold_reset(2'd1);
    release_reset();
    while (n < 20) step();
    for (int k = 0; k < 8; k++)
      check($sformatf("bar%0d", k), rgb_t[4 + k], bars_exp[k]);
    check("bar_blank", rgb_t[12], 0);

    // Asynchronous reset in the middle of line 1
    hold_reset(2'd0);
    release_reset();
    while (n < 18) step();
    check("pre_rst_red", r, 2);
    check("pre_rst_blank", bl, 0);
    #3 rst = 1'b1;
    #1;
    check("async_blank", bl, 1);
    check("async_rgb", {r, g, b}, 0);
    check("async_fetch_valid", fv, 0);
    check("async_hsync_n", hs_n, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    while (!fs && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("fs_after_rst", cnt, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
